openhw_flopen_arb: RTL and testbench
====================================

OPENHW_FLOPEN_ARB -- requirements
Module: openhw_flopen_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..16).
REQ-002 Parameter WIDTH, default 32, SHALL set the shared register width.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port Req, input, NREQ bits, SHALL carry the per-requester write request.
REQ-006 Port D, input, NREQ*WIDTH bits, SHALL carry write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port Lock, input, NREQ bits, SHALL carry the per-requester lock request; present only under the configuration macro.
REQ-008 Port Ack, output, NREQ bits, SHALL pulse the bit of the requester whose write just completed.
REQ-009 Port Q, output, WIDTH bits, SHALL be the shared register contents.
REQ-010 Port Owner, output, $clog2(NREQ) bits, SHALL give the index of the last writer.
REQ-011 Port Valid, output, 1 bit, SHALL indicate that Q has been written at least once since reset.

Function
REQ-012 The block SHALL own one shared enable-gated register and grant at most one write per cycle.
REQ-013 Arbitration SHALL be round-robin: search starts at index Ptr+1 modulo NREQ; the first set Req bit wins.
REQ-014 Winner j sampled at edge k SHALL have Q=D[j], Owner=j, Ack=one-hot j, and Ptr=j visible after edge k; write latency is 1 cycle.
REQ-015 Ack SHALL be a single-cycle pulse; all Ack bits are 0 in any cycle following an edge with no grant.
REQ-016 Requesters SHALL hold Req and D stable until Ack; Req still high in the Ack cycle SHALL count as a new request.
REQ-017 With no Req set, Q, Owner and Ptr SHALL hold their values.
REQ-018 Valid SHALL go to 1 on the first grant after reset and stay at 1 until reset.
REQ-019 FSM states SHALL be IDLE (no grant last edge), GRANT (grant last edge) and HOLD (locked).
REQ-020 Transitions: IDLE/GRANT go to GRANT on any grant and to IDLE on none; HOLD is entered and left only per REQ-026..REQ-028.
REQ-021 Simultaneous requests from all NREQ requesters SHALL each be granted exactly once within NREQ consecutive cycles.
REQ-022 Pointer wrap SHALL occur from NREQ-1 to 0.

Reset
REQ-023 With reset high at an edge, that edge SHALL set Q=0, Owner=0, Valid=0, Ack=0, Ptr=NREQ-1 and state IDLE.
REQ-024 Reset SHALL dominate: requests sampled while reset is high SHALL be dropped and not acknowledged.
REQ-025 After reset, requester 0 SHALL have the highest priority at the first arbitration.

Configuration
REQ-026 With macro OPENHW_FLOPEN_ARB_LOCK_EN defined, the Lock port SHALL exist; a grant to j with Lock[j]=1 SHALL move the FSM to HOLD.
REQ-027 In HOLD, only Req[Owner] SHALL be granted; all other requests stall without Ack, and Ptr is frozen.
REQ-028 HOLD SHALL exit to IDLE on the first edge sampling Lock[Owner]=0; a grant to Owner in that same cycle is still performed and the next state is GRANT.
REQ-029 With the macro undefined, the Lock port and HOLD state SHALL be absent; behaviour equals the macro-defined build with Lock tied to 0.

Verification
REQ-030 Reset held 2 cycles, with Req=4'b1111 -> after release Q=0, Valid=0, Ack=0; the first grant goes to requester 0.
REQ-031 NREQ=4, WIDTH=8, Req=4'b1111 held, D={8'h44,8'h33,8'h22,8'h11} -> Q sequence 11,22,33,44,11; Ack 0001,0010,0100,1000,0001.
REQ-032 Single Req[2] for one cycle with D2=8'hA5 -> next cycle Q=A5, Owner=2, Ack=4'b0100, Valid=1; following cycle Ack=0 and Q holds A5.
REQ-033 Ptr=3, Req=4'b1001 -> grant 0 (wrap), then grant 3.
REQ-034 Reset asserted in the cycle Req[1] is sampled -> no Ack[1], Q=0; Req[1] held is granted on the first edge after release.
REQ-035 LOCK_EN: requester 1 is granted with Lock[1]=1 while Req[0] and Req[2] are held -> Req[0] and Req[2] are starved until Lock[1]=0 is sampled, then round-robin resumes from Ptr=1 with a grant to 2.

Source files
------------

// File: rtl/openhw_flopen_arb.sv
// openhw_flopen_arb: round-robin arbiter in front of one shared,
// enable-gated register. At most one requester writes per cycle. The winner
// is acknowledged, recorded as Owner and becomes the new round-robin pointer.
//
// Optional feature macro: OPENHW_FLOPEN_ARB_LOCK_EN
//   Defined   : adds the Lock port and the HOLD state. A locked owner keeps
//               exclusive access until it drops its Lock bit.
//   Undefined : no Lock port and no HOLD state. Behaves as the locked build
//               with Lock tied to 0.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no grant on the last edge
// GRANT | a grant was made on the last edge
// HOLD  | register locked to Owner (lock build only)
module openhw_flopen_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ*WIDTH-1:0]     D,
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
    input  logic [NREQ-1:0]           Lock,
`endif
    output logic [NREQ-1:0]           Ack,
    output logic [WIDTH-1:0]          Q,
    output logic [$clog2(NREQ)-1:0]   Owner,
    output logic                      Valid
);

    localparam int PW = $clog2(NREQ);

`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_ack;
    logic [WIDTH-1:0]  r_q;
    logic [PW-1:0]     r_owner;
    logic              r_valid;

    logic              w_rr_found;
    logic [PW-1:0]     w_rr_idx;
    logic              w_gnt;
    logic [PW-1:0]     w_gnt_idx;
    logic              w_ptr_en;
    logic [NREQ-1:0]   w_ack_nxt;

    // Reduce an index that may have run past the top back into 0..NREQ-1.
    function automatic logic [PW-1:0] f_wrap(input int v);
        return PW'(v % NREQ);
    endfunction

    // Round-robin search: first set request at or after Ptr+1, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_rr_found && Req[f_wrap(int'(r_ptr) + k)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = f_wrap(int'(r_ptr) + k);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
            S_HOLD: begin
                if (Lock[r_owner]) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = w_gnt ? S_GRANT : S_IDLE;
                end
            end
`endif
            default: begin
                if (w_gnt) begin
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
                    w_state_nxt = Lock[w_gnt_idx] ? S_HOLD : S_GRANT;
`else
                    w_state_nxt = S_GRANT;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Output logic: pick the grant (owner only while locked) and form Ack.
    always_comb begin
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
        if (r_state == S_HOLD) begin
            w_gnt     = Req[r_owner];
            w_gnt_idx = r_owner;
            w_ptr_en  = 1'b0;
        end else begin
            w_gnt     = w_rr_found;
            w_gnt_idx = w_rr_idx;
            w_ptr_en  = w_rr_found;
        end
`else
        w_gnt     = w_rr_found;
        w_gnt_idx = w_rr_idx;
        w_ptr_en  = w_rr_found;
`endif
        w_ack_nxt = w_gnt ? (NREQ'(1) << w_gnt_idx) : '0;
    end

    // Shared register, owner, pointer and acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
            r_ack   <= '0;
            r_ptr   <= PW'(NREQ - 1);
        end else begin
            r_ack <= w_ack_nxt;
            if (w_gnt) begin
                r_q     <= D[int'(w_gnt_idx)*WIDTH +: WIDTH];
                r_owner <= w_gnt_idx;
                r_valid <= 1'b1;
            end
            if (w_ptr_en) begin
                r_ptr <= w_gnt_idx;
            end
        end
    end

    assign Ack   = r_ack;
    assign Q     = r_q;
    assign Owner = r_owner;
    assign Valid = r_valid;

endmodule

// File: tb/tb_openhw_flopen_arb.sv
// Bench for openhw_flopen_arb (NREQ=4, WIDTH=8): directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_openhw_flopen_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       Req;
    logic [NREQ*WIDTH-1:0] D;
    logic [NREQ-1:0]       Lock;
    logic [NREQ-1:0]       Ack;
    logic [WIDTH-1:0]      Q;
    logic [1:0]            Owner;
    logic                  Valid;

    int checks   = 0;
    int failures = 0;

    openhw_flopen_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .Req   (Req),
        .D     (D),
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
        .Lock  (Lock),
`endif
        .Ack   (Ack),
        .Q     (Q),
        .Owner (Owner),
        .Valid (Valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [NREQ-1:0]  m_ack;
    logic [WIDTH-1:0] m_q;
    logic [1:0]       m_owner;
    logic [1:0]       m_ptr;
    logic             m_valid;
    logic             m_locked;

    task automatic model_edge();
        int win;
        logic was_locked;
        logic [NREQ-1:0] lk;
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
        lk = Lock;
`else
        lk = '0;
`endif
        if (reset) begin
            m_ack = '0; m_q = '0; m_owner = '0; m_valid = 1'b0;
            m_ptr = 2'(NREQ - 1); m_locked = 1'b0;
        end else begin
            win = -1;
            was_locked = m_locked;
            if (m_locked) begin
                if (Req[m_owner]) win = int'(m_owner);
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (int'(m_ptr) + k) % NREQ;
                    if (win < 0 && Req[idx]) win = idx;
                end
            end
            m_ack = (win >= 0) ? NREQ'(1 << win) : '0;
            if (win >= 0) begin
                m_q     = D[win*WIDTH +: WIDTH];
                m_owner = 2'(win);
                m_valid = 1'b1;
                if (!was_locked) m_ptr = 2'(win);
            end
            if (was_locked) m_locked = lk[m_owner];
            else            m_locked = (win >= 0) && lk[win];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; Req = '0; Lock = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; Req = 4'b1111; Lock = '0;
        D = {8'h44, 8'h33, 8'h22, 8'h11};
        step();
        step();
        checks++;
        if (Ack !== 4'b0000 || Q !== 8'h00 || Valid !== 1'b0 || Owner !== 2'd0) begin
            failures++;
            $display("FAIL reset_state ack=%b q=%h valid=%b owner=%0d expected ack=0000 q=00 valid=0 owner=0",
                     Ack, Q, Valid, Owner);
        end
        reset = 1'b0;
        step();
        checks++;
        if (Ack !== 4'b0001 || Owner !== 2'd0 || Q !== 8'h11 || Valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant ack=%b owner=%0d q=%h valid=%b expected ack=0001 owner=0 q=11 valid=1",
                     Ack, Owner, Q, Valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_q [5];
        logic [3:0] exp_a [5];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        Req = 4'b1111;
        D = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (Q !== exp_q[i] || Ack !== exp_a[i]) begin
                failures++;
                $display("FAIL round_robin[%0d] q=%h ack=%b expected q=%h ack=%b",
                         i, Q, Ack, exp_q[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        Req = 4'b0100;
        D[23:16] = 8'hA5;
        step();
        Req = '0;
        checks++;
        if (Q !== 8'hA5 || Owner !== 2'd2 || Ack !== 4'b0100 || Valid !== 1'b1) begin
            failures++;
            $display("FAIL single_grant q=%h owner=%0d ack=%b valid=%b expected q=a5 owner=2 ack=0100 valid=1",
                     Q, Owner, Ack, Valid);
        end
        step();
        checks++;
        if (Ack !== 4'b0000 || Q !== 8'hA5 || Owner !== 2'd2) begin
            failures++;
            $display("FAIL single_hold ack=%b q=%h owner=%0d expected ack=0000 q=a5 owner=2", Ack, Q, Owner);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        Req = 4'b1000;
        step();
        Req = 4'b1001;
        step();
        checks++;
        if (Ack !== 4'b0001 || Owner !== 2'd0) begin
            failures++;
            $display("FAIL wrap_grant0 ack=%b owner=%0d expected ack=0001 owner=0", Ack, Owner);
        end
        Req = 4'b1000;
        step();
        checks++;
        if (Ack !== 4'b1000 || Owner !== 2'd3) begin
            failures++;
            $display("FAIL wrap_grant3 ack=%b owner=%0d expected ack=1000 owner=3", Ack, Owner);
        end
    endtask

    task automatic test_reset_drop();
        do_reset();
        Req = 4'b0010;
        D[15:8] = 8'h7C;
        reset = 1'b1;
        step();
        checks++;
        if (Ack !== 4'b0000 || Q !== 8'h00 || Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop ack=%b q=%h valid=%b expected ack=0000 q=00 valid=0", Ack, Q, Valid);
        end
        reset = 1'b0;
        step();
        checks++;
        if (Ack !== 4'b0010 || Q !== 8'h7C) begin
            failures++;
            $display("FAIL reset_release_grant ack=%b q=%h expected ack=0010 q=7c", Ack, Q);
        end
    endtask

`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        Req = 4'b0010; Lock = 4'b0010;
        D = {8'h44, 8'h33, 8'h5A, 8'h11};
        step();
        checks++;
        if (Ack !== 4'b0010 || Q !== 8'h5A) begin
            failures++;
            $display("FAIL lock_grant ack=%b q=%h expected ack=0010 q=5a", Ack, Q);
        end
        Req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Ack !== 4'b0000 || Owner !== 2'd1 || Q !== 8'h5A) begin
                failures++;
                $display("FAIL lock_starve[%0d] ack=%b owner=%0d q=%h expected ack=0000 owner=1 q=5a",
                         i, Ack, Owner, Q);
            end
        end
        Req = 4'b0111;
        step();
        checks++;
        if (Ack !== 4'b0010) begin
            failures++;
            $display("FAIL lock_owner_regrant ack=%b expected 0010", Ack);
        end
        Req = 4'b0101; Lock = 4'b0000;
        step();
        checks++;
        if (Ack !== 4'b0000) begin
            failures++;
            $display("FAIL lock_exit ack=%b expected 0000", Ack);
        end
        step();
        checks++;
        if (Ack !== 4'b0100 || Q !== 8'h33) begin
            failures++;
            $display("FAIL lock_resume ack=%b q=%h expected ack=0100 q=33", Ack, Q);
        end
        Req = 4'b0001;
        step();
        checks++;
        if (Ack !== 4'b0001 || Q !== 8'h11) begin
            failures++;
            $display("FAIL lock_resume_next ack=%b q=%h expected ack=0001 q=11", Ack, Q);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i] || !Req[i]) begin
                    Req[i] = m_ack[i] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                    D[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            Lock  = 4'($urandom) & 4'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            step();
            checks++;
            if ({Ack, Q, Owner, Valid} !== {m_ack, m_q, m_owner, m_valid}) begin
                failures++;
                $display("FAIL random[%0d] ack=%b q=%h owner=%0d valid=%b expected ack=%b q=%h owner=%0d valid=%b",
                         c, Ack, Q, Owner, Valid, m_ack, m_q, m_owner, m_valid);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Req = '0; D = '0; Lock = '0;
        m_ack = '0; m_q = '0; m_owner = '0; m_ptr = 2'd3; m_valid = 1'b0; m_locked = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_reset_drop();
`ifdef OPENHW_FLOPEN_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
